// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the complete-stage CDB arbiter: sizes, tag type and the
// broadcast packet that both the holding registers and the CDB lanes carry.
package cdb_arbiter_pkg;

    localparam int NUM_FU = 4;
    localparam int CDB_SZ = 2;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef logic [TAG_W-1:0] PHYS_REG_IDX;

    typedef struct packed {
        logic              valid;
        PHYS_REG_IDX       tag;
        logic [DATA_W-1:0] data;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr_pick_n.sv
// Round-robin picker: grants up to CDB_SZ requesters scanning from ptr_i,
// reporting per-lane one-hots and the index of the last grant.
module rr_pick_n #(
    parameter  int NUM_FU = 4,
    parameter  int CDB_SZ = 2,
    localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic [NUM_FU-1:0]              req_i,
    input  logic [PTR_W-1:0]               ptr_i,
    output logic [NUM_FU-1:0]              grant_o,
    output logic [CDB_SZ-1:0][NUM_FU-1:0]  lane_oh_o,
    output logic                           any_o,
    output logic [PTR_W-1:0]               last_o
);

    int             pos;
    int             n_granted;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o   = '0;
        lane_oh_o = '0;
        any_o     = 1'b0;
        last_o    = '0;
        pos       = 0;
        n_granted = 0;
        idx       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_FU) pos = pos - NUM_FU;
            idx = PTR_W'(pos);
            if (req_i[idx] && (n_granted < CDB_SZ)) begin
                grant_o[idx] = 1'b1;
                for (int l = 0; l < CDB_SZ; l++) begin
                    if (l == n_granted) lane_oh_o[l][idx] = 1'b1;
                end
                last_o    = idx;
                any_o     = 1'b1;
                n_granted = n_granted + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Complete-stage arbiter: per-FU holding registers, round-robin grant onto
// registered CDB lanes. Optional performance counters under `CDB_PERF_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash_i,
    input  logic [NUM_FU-1:0]          fu_valid_i,
    input  logic [NUM_FU*TAG_W-1:0]    fu_tag_i,
    input  logic [NUM_FU*DATA_W-1:0]   fu_data_i,
    output logic [NUM_FU-1:0]          fu_stall_o,
    output logic [CDB_SZ-1:0]          cdb_valid_o,
    output logic [CDB_SZ*TAG_W-1:0]    cdb_tag_o,
    output logic [CDB_SZ*DATA_W-1:0]   cdb_data_o,
    output logic [31:0]                perf_bcast_o,
    output logic [31:0]                perf_stall_o
);

    CDB_PACKET [NUM_FU-1:0]             hold_q, hold_d;
    CDB_PACKET [CDB_SZ-1:0]             cdb_q, cdb_d;
    logic      [NUM_FU-1:0]             hold_vld;
    logic      [NUM_FU-1:0]             grant;
    logic      [CDB_SZ-1:0][NUM_FU-1:0] lane_oh;
    logic                               any_grant;
    logic      [PTR_W-1:0]              last_idx;
    logic      [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) hold_vld[i] = hold_q[i].valid;
    end

    rr_pick_n #(.NUM_FU(NUM_FU), .CDB_SZ(CDB_SZ)) u_pick (
        .req_i     (hold_vld),
        .ptr_i     (rr_ptr_q),
        .grant_o   (grant),
        .lane_oh_o (lane_oh),
        .any_o     (any_grant),
        .last_o    (last_idx)
    );

    // Stall depends only on registered state, never on fu_valid_i.
    assign fu_stall_o = hold_vld & ~grant;

    always_comb begin
        hold_d = hold_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (squash_i) begin
                hold_d[i].valid = 1'b0;
            end else if (fu_valid_i[i] && !fu_stall_o[i]) begin
                hold_d[i].valid = 1'b1;
                hold_d[i].tag   = fu_tag_i[i*TAG_W +: TAG_W];
                hold_d[i].data  = fu_data_i[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
                hold_d[i].valid = 1'b0;
            end
        end
    end

    // A granted x0 result still takes its lane slot but broadcasts nothing.
    always_comb begin
        cdb_d = '0;
        if (!squash_i) begin
            for (int l = 0; l < CDB_SZ; l++) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (lane_oh[l][i] && (hold_q[i].tag != '0)) cdb_d[l] = hold_q[i];
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!squash_i && any_grant) begin
            rr_ptr_d = (int'(last_idx) == NUM_FU - 1) ? '0 : PTR_W'(last_idx + 1'b1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q   <= '0;
            cdb_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            hold_q   <= hold_d;
            cdb_q    <= cdb_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        for (int l = 0; l < CDB_SZ; l++) begin
            cdb_valid_o[l]                   = cdb_q[l].valid;
            cdb_tag_o[l*TAG_W +: TAG_W]      = cdb_q[l].tag;
            cdb_data_o[l*DATA_W +: DATA_W]   = cdb_q[l].data;
        end
    end

`ifdef CDB_PERF_EN
    logic [CDB_SZ-1:0] cdb_vld_d;
    logic [31:0]       perf_bcast_q, perf_stall_q;

    always_comb begin
        for (int l = 0; l < CDB_SZ; l++) cdb_vld_d[l] = cdb_d[l].valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_bcast_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_bcast_q <= perf_bcast_q + 32'($countones(cdb_vld_d));
            perf_stall_q <= perf_stall_q + {31'd0, |fu_stall_o};
        end
    end

    assign perf_bcast_o = perf_bcast_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_bcast_o = '0;
    assign perf_stall_o = '0;
`endif

    a_no_valid_while_stalled: assert property (
        @(posedge clock) disable iff (reset) ((fu_valid_i & fu_stall_o) == '0)
    );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (4 FUs, 2 lanes).
module tb_cdb_arbiter;

    localparam int NF = 4;
    localparam int NL = 2;
    localparam int TW = 6;
    localparam int DW = 32;

`ifdef CDB_PERF_EN
    localparam logic [31:0] EXP_BCAST = 32'd4;
    localparam logic [31:0] EXP_STALL = 32'd1;
`else
    localparam logic [31:0] EXP_BCAST = 32'd0;
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    logic [NF-1:0]     fu_valid;
    logic [NF*TW-1:0]  fu_tag;
    logic [NF*DW-1:0]  fu_data;
    logic [NF-1:0]     fu_stall;
    logic [NL-1:0]     cdb_valid;
    logic [NL*TW-1:0]  cdb_tag;
    logic [NL*DW-1:0]  cdb_data;
    logic [31:0]       perf_bcast;
    logic [31:0]       perf_stall;

    int n_cmp = 0;
    int n_bad = 0;

    cdb_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .squash_i     (squash),
        .fu_valid_i   (fu_valid),
        .fu_tag_i     (fu_tag),
        .fu_data_i    (fu_data),
        .fu_stall_o   (fu_stall),
        .cdb_valid_o  (cdb_valid),
        .cdb_tag_o    (cdb_tag),
        .cdb_data_o   (cdb_data),
        .perf_bcast_o (perf_bcast),
        .perf_stall_o (perf_stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_fu();
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
    endtask

    task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        fu_valid[i]         = 1'b1;
        fu_tag[i*TW +: TW]  = t;
        fu_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        squash = 1'b0;
        clear_fu();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [TW-1:0] ltag(input int l);
        return cdb_tag[l*TW +: TW];
    endfunction

    function automatic logic [DW-1:0] ldata(input int l);
        return cdb_data[l*DW +: DW];
    endfunction

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        clear_fu();
        tick();
        tick();
        reset = 1'b0;

        // Reset state and single-result latency
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_fu_stall",  64'(fu_stall),  64'h0);
        chk("rst_perf_bcast", 64'(perf_bcast), 64'h0);
        chk("rst_perf_stall", 64'(perf_stall), 64'h0);
        set_fu(0, 6'd5, 32'h1234);
        tick();
        clear_fu();
        chk("t1_stall_held",  64'(fu_stall),  64'h0);
        chk("t1_cdb_early",   64'(cdb_valid), 64'h0);
        tick();
        chk("t1_cdb_valid",   64'(cdb_valid), 64'h1);
        chk("t1_cdb_tag0",    64'(ltag(0)),   64'd5);
        chk("t1_cdb_data0",   64'(ldata(0)),  64'h1234);
        chk("t1_lane1_tag",   64'(ltag(1)),   64'h0);
        tick();
        chk("t1_cdb_drain",   64'(cdb_valid), 64'h0);

        // All four FUs at once
        do_reset();
        set_fu(0, 6'd1, 32'hA0);
        set_fu(1, 6'd2, 32'hA1);
        set_fu(2, 6'd3, 32'hA2);
        set_fu(3, 6'd4, 32'hA3);
        tick();
        clear_fu();
        chk("t2_stall_full",  64'(fu_stall),  64'hC);
        chk("t2_cdb_none",    64'(cdb_valid), 64'h0);
        tick();
        chk("t2_g1_valid",    64'(cdb_valid), 64'h3);
        chk("t2_g1_tag0",     64'(ltag(0)),   64'd1);
        chk("t2_g1_tag1",     64'(ltag(1)),   64'd2);
        chk("t2_g1_data1",    64'(ldata(1)),  64'hA1);
        chk("t2_g1_stall",    64'(fu_stall),  64'h0);
        tick();
        chk("t2_g2_valid",    64'(cdb_valid), 64'h3);
        chk("t2_g2_tag0",     64'(ltag(0)),   64'd3);
        chk("t2_g2_tag1",     64'(ltag(1)),   64'd4);
        chk("t2_g2_data0",    64'(ldata(0)),  64'hA2);
        chk("t6_perf_bcast",  64'(perf_bcast), 64'(EXP_BCAST));
        chk("t6_perf_stall",  64'(perf_stall), 64'(EXP_STALL));
        tick();
        chk("t2_drain",       64'(cdb_valid), 64'h0);

        // Grant and new capture on the same FU in one cycle
        do_reset();
        set_fu(0, 6'd7, 32'hAAAA_0001);
        tick();
        set_fu(0, 6'd8, 32'hBBBB_0002);
        chk("t3_no_stall",    64'(fu_stall),  64'h0);
        tick();
        clear_fu();
        chk("t3_old_valid",   64'(cdb_valid), 64'h1);
        chk("t3_old_tag",     64'(ltag(0)),   64'd7);
        chk("t3_old_data",    64'(ldata(0)),  64'hAAAA_0001);
        chk("t3_stall2",      64'(fu_stall),  64'h0);
        tick();
        chk("t3_new_valid",   64'(cdb_valid), 64'h1);
        chk("t3_new_tag",     64'(ltag(0)),   64'd8);
        chk("t3_new_data",    64'(ldata(0)),  64'hBBBB_0002);

        // x0 destination alone, then sharing a grant round
        do_reset();
        set_fu(1, 6'd0, 32'hDEAD);
        tick();
        clear_fu();
        chk("t4_stall",       64'(fu_stall),  64'h0);
        tick();
        chk("t4_cdb_valid",   64'(cdb_valid), 64'h0);
        chk("t4_cdb_tag",     64'(ltag(0)),   64'h0);
        tick();
        chk("t4_cleared",     64'(cdb_valid), 64'h0);
        do_reset();
        set_fu(1, 6'd0, 32'hDEAD);
        set_fu(2, 6'd9, 32'hC2);
        set_fu(3, 6'd10, 32'hC3);
        tick();
        clear_fu();
        chk("t4b_stall",      64'(fu_stall),  64'h8);
        tick();
        chk("t4b_valid",      64'(cdb_valid), 64'h2);
        chk("t4b_lane0_tag",  64'(ltag(0)),   64'h0);
        chk("t4b_lane1_tag",  64'(ltag(1)),   64'd9);
        tick();
        chk("t4b_valid2",     64'(cdb_valid), 64'h1);
        chk("t4b_tag2",       64'(ltag(0)),   64'd10);

        // Squash keeps rr_ptr (moved to 2 first) and drops same-cycle results
        do_reset();
        set_fu(1, 6'd11, 32'hD1);
        tick();
        clear_fu();
        tick();
        chk("t5_pre_tag",     64'(ltag(0)),   64'd11);
        tick();
        set_fu(0, 6'd12, 32'hE0);
        set_fu(1, 6'd13, 32'hE1);
        set_fu(2, 6'd14, 32'hE2);
        tick();
        clear_fu();
        chk("t5_pre_stall",   64'(fu_stall),  64'h2);
        squash = 1'b1;
        set_fu(3, 6'd15, 32'hE3);
        tick();
        squash = 1'b0;
        clear_fu();
        chk("t5_sq_valid",    64'(cdb_valid), 64'h0);
        chk("t5_sq_stall",    64'(fu_stall),  64'h0);
        tick();
        chk("t5_sq_dropped",  64'(cdb_valid), 64'h0);
        set_fu(0, 6'd16, 32'hF0);
        set_fu(1, 6'd17, 32'hF1);
        set_fu(3, 6'd18, 32'hF3);
        tick();
        clear_fu();
        chk("t5_ptr_stall",   64'(fu_stall),  64'h2);
        tick();
        chk("t5_ptr_valid",   64'(cdb_valid), 64'h3);
        chk("t5_ptr_tag0",    64'(ltag(0)),   64'd18);
        chk("t5_ptr_tag1",    64'(ltag(1)),   64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
